// File: rtl/tdd_frame_sequencer.sv
// rtl/tdd_frame_sequencer.sv - TDD frame timing core with shadowed configuration
//
// Runs a frame counter through IDLE/ARMED/WAITING/RUNNING and derives
// CHANNEL_COUNT on/off windows from it. Every generation decision reads only
// the shadow copies of the configuration. The shadow copies are loaded when
// leaving IDLE, and at a frame end while an update request is pending.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   tdd_enable          level; low returns the core to IDLE
//   tdd_sync            single-cycle start / resync pulse
//   tdd_sync_rst        1: tdd_sync while RUNNING restarts the frame
//   tdd_cfg_update      request a shadow load at the next frame end
//   tdd_startup_delay   cycles spent in WAITING
//   tdd_frame_length    frame period minus one
//   tdd_burst_count     frames per burst, 0 = endless
//   tdd_channel_en/pol  per-channel enable and polarity (1 = active low)
//   tdd_channel_on/off  packed per-channel window edges, RW bits each
//   tdd_channel         registered channel outputs
//   tdd_cstate          current state, tdd_counter current count
//   tdd_endof_frame     high on the last cycle of every frame
//   tdd_endof_burst     high on the last cycle of a finite burst

module tdd_frame_sequencer #(
   parameter int CHANNEL_COUNT     = 8,
   parameter int REGISTER_WIDTH    = 32,
   parameter int BURST_COUNT_WIDTH = 32
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     tdd_enable,
   input  logic                                     tdd_sync,
   input  logic                                     tdd_sync_rst,
   input  logic                                     tdd_cfg_update,
   input  logic [REGISTER_WIDTH-1:0]                tdd_startup_delay,
   input  logic [REGISTER_WIDTH-1:0]                tdd_frame_length,
   input  logic [BURST_COUNT_WIDTH-1:0]             tdd_burst_count,
   input  logic [CHANNEL_COUNT-1:0]                 tdd_channel_en,
   input  logic [CHANNEL_COUNT-1:0]                 tdd_channel_pol,
   input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  tdd_channel_on,
   input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  tdd_channel_off,
   output logic [CHANNEL_COUNT-1:0]                 tdd_channel,
   output logic [1:0]                               tdd_cstate,
   output logic [REGISTER_WIDTH-1:0]                tdd_counter,
   output logic                                     tdd_endof_frame,
   output logic                                     tdd_endof_burst
);

   localparam int CH = CHANNEL_COUNT;
   localparam int RW = REGISTER_WIDTH;
   localparam int BW = BURST_COUNT_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_WAITING = 2'd2,
      ST_RUNNING = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [RW-1:0]     counter, counter_nxt;
   logic [BW-1:0]     frame_cnt, frame_cnt_nxt;
   logic              pending, pending_nxt;
   logic              load;

   logic [RW-1:0]     sh_delay;
   logic [RW-1:0]     sh_frame_len;
   logic [BW-1:0]     sh_burst;
   logic [CH-1:0]     sh_en;
   logic [CH-1:0]     sh_pol;
   logic [CH*RW-1:0]  sh_on;
   logic [CH*RW-1:0]  sh_off;

   logic [CH-1:0]     flag, flag_nxt;
   logic [CH-1:0]     channel;
   logic [CH-1:0]     en_nxt, pol_nxt;

   logic              resync;
   logic              frame_end;
   logic              last_frame;

   // A resync swallows the frame end it may coincide with: no pulse, no
   // frame count, no shadow load.
   assign resync     = (state == ST_RUNNING) && tdd_sync && tdd_sync_rst;
   assign frame_end  = (state == ST_RUNNING) && (counter == sh_frame_len) && !resync;
   assign last_frame = (sh_burst != '0) && (frame_cnt == sh_burst - BW'(1));

   always_comb begin
      state_nxt     = state;
      counter_nxt   = counter;
      frame_cnt_nxt = frame_cnt;
      load          = 1'b0;
      if (!tdd_enable) begin
         state_nxt     = ST_IDLE;
         counter_nxt   = '0;
         frame_cnt_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt   = ST_ARMED;
               counter_nxt = '0;
               load        = 1'b1;
            end
            ST_ARMED: begin
               counter_nxt = '0;
               if (tdd_sync) begin
                  state_nxt = (sh_delay != '0) ? ST_WAITING : ST_RUNNING;
               end
            end
            ST_WAITING: begin
               if (counter == sh_delay - RW'(1)) begin
                  state_nxt   = ST_RUNNING;
                  counter_nxt = '0;
               end else begin
                  counter_nxt = counter + RW'(1);
               end
            end
            ST_RUNNING: begin
               if (resync) begin
                  counter_nxt   = '0;
                  frame_cnt_nxt = '0;
               end else if (frame_end) begin
                  counter_nxt = '0;
                  load        = pending;
                  if (last_frame) begin
                     state_nxt     = ST_ARMED;
                     frame_cnt_nxt = '0;
                  end else begin
                     frame_cnt_nxt = frame_cnt + BW'(1);
                  end
               end else begin
                  counter_nxt = counter + RW'(1);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // An update arriving in the same cycle as a load survives it.
   always_comb begin
      pending_nxt = pending | tdd_cfg_update;
      if (!tdd_enable) begin
         pending_nxt = 1'b0;
      end else if (load) begin
         pending_nxt = tdd_cfg_update;
      end
   end

   // Flags only evolve while RUNNING stays RUNNING without a resync; they are
   // held across frame wraps so an on > off window spans the boundary.
   always_comb begin
      flag_nxt = '0;
      if ((state == ST_RUNNING) && (state_nxt == ST_RUNNING) && !resync) begin
         for (int n = 0; n < CH; n++) begin
            if (counter == sh_off[n*RW +: RW]) begin
               flag_nxt[n] = 1'b0;
            end else if (counter == sh_on[n*RW +: RW]) begin
               flag_nxt[n] = 1'b1;
            end else begin
               flag_nxt[n] = flag[n];
            end
         end
      end
   end

   // The output register uses the enable/polarity that will be in force next
   // cycle so a shadow load and the output change line up.
   assign en_nxt  = load ? tdd_channel_en  : sh_en;
   assign pol_nxt = load ? tdd_channel_pol : sh_pol;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         counter      <= '0;
         frame_cnt    <= '0;
         pending      <= 1'b0;
         sh_delay     <= '0;
         sh_frame_len <= '0;
         sh_burst     <= '0;
         sh_en        <= '0;
         sh_pol       <= '0;
         sh_on        <= '0;
         sh_off       <= '0;
         flag         <= '0;
         channel      <= '0;
      end else begin
         state     <= state_nxt;
         counter   <= counter_nxt;
         frame_cnt <= frame_cnt_nxt;
         pending   <= pending_nxt;
         flag      <= flag_nxt;
         channel   <= (flag_nxt & en_nxt) ^ pol_nxt;
         if (load) begin
            sh_delay     <= tdd_startup_delay;
            sh_frame_len <= tdd_frame_length;
            sh_burst     <= tdd_burst_count;
            sh_en        <= tdd_channel_en;
            sh_pol       <= tdd_channel_pol;
            sh_on        <= tdd_channel_on;
            sh_off       <= tdd_channel_off;
         end
      end
   end

   assign tdd_channel     = channel;
   assign tdd_cstate      = state;
   assign tdd_counter     = counter;
   assign tdd_endof_frame = frame_end;
   assign tdd_endof_burst = frame_end && last_frame;

endmodule

// File: tb/tb_tdd_frame_sequencer.sv
// tb/tb_tdd_frame_sequencer.sv - directed vector bench for tdd_frame_sequencer

module tb_tdd_frame_sequencer;

   logic        clk;
   logic        rst;
   logic        tdd_enable;
   logic        tdd_sync;
   logic        tdd_sync_rst;
   logic        tdd_cfg_update;
   logic [7:0]  tdd_startup_delay;
   logic [7:0]  tdd_frame_length;
   logic [7:0]  tdd_burst_count;
   logic [1:0]  tdd_channel_en;
   logic [1:0]  tdd_channel_pol;
   logic [15:0] tdd_channel_on;
   logic [15:0] tdd_channel_off;
   logic [1:0]  tdd_channel;
   logic [1:0]  tdd_cstate;
   logic [7:0]  tdd_counter;
   logic        tdd_endof_frame;
   logic        tdd_endof_burst;

   int n_checks = 0;
   int n_fail   = 0;

   tdd_frame_sequencer #(
      .CHANNEL_COUNT    (2),
      .REGISTER_WIDTH   (8),
      .BURST_COUNT_WIDTH(8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .tdd_enable       (tdd_enable),
      .tdd_sync         (tdd_sync),
      .tdd_sync_rst     (tdd_sync_rst),
      .tdd_cfg_update   (tdd_cfg_update),
      .tdd_startup_delay(tdd_startup_delay),
      .tdd_frame_length (tdd_frame_length),
      .tdd_burst_count  (tdd_burst_count),
      .tdd_channel_en   (tdd_channel_en),
      .tdd_channel_pol  (tdd_channel_pol),
      .tdd_channel_on   (tdd_channel_on),
      .tdd_channel_off  (tdd_channel_off),
      .tdd_channel      (tdd_channel),
      .tdd_cstate       (tdd_cstate),
      .tdd_counter      (tdd_counter),
      .tdd_endof_frame  (tdd_endof_frame),
      .tdd_endof_burst  (tdd_endof_burst)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      int         cfg;
      logic       en;
      logic       sync;
      logic       srst;
      logic       upd;
      logic [1:0] st;
      logic [7:0] cnt;
      logic [1:0] ch;
      logic       eof;
      logic       eob;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int cfg, input logic en, input logic sync, input logic srst,
                      input logic upd, input logic [1:0] st, input int cnt,
                      input logic [1:0] ch, input logic eof, input logic eob);
      vec_t v;
      v.cfg = cfg; v.en = en; v.sync = sync; v.srst = srst; v.upd = upd;
      v.st = st; v.cnt = cnt[7:0]; v.ch = ch; v.eof = eof; v.eob = eob;
      tbl.push_back(v);
   endtask

   // Channel n packs at [n*8 +: 8], so literals read {ch1, ch0}.
   task automatic drive_cfg(input int k);
      case (k)
         0: begin
            tdd_startup_delay = 8'd3; tdd_frame_length = 8'd9; tdd_burst_count = 8'd2;
            tdd_channel_en = 2'b01; tdd_channel_pol = 2'b00;
            tdd_channel_on = {8'd0, 8'd2}; tdd_channel_off = {8'd0, 8'd5};
         end
         1: begin
            tdd_startup_delay = 8'd2; tdd_frame_length = 8'd9; tdd_burst_count = 8'd0;
            tdd_channel_en = 2'b11; tdd_channel_pol = 2'b10;
            tdd_channel_on = {8'd8, 8'd2}; tdd_channel_off = {8'd1, 8'd7};
         end
         2: begin
            tdd_startup_delay = 8'd2; tdd_frame_length = 8'd4; tdd_burst_count = 8'd0;
            tdd_channel_en = 2'b11; tdd_channel_pol = 2'b10;
            tdd_channel_on = {8'd8, 8'd2}; tdd_channel_off = {8'd1, 8'd4};
         end
         default: begin
            tdd_startup_delay = 8'd0; tdd_frame_length = 8'd4; tdd_burst_count = 8'd0;
            tdd_channel_en = 2'b01; tdd_channel_pol = 2'b00;
            tdd_channel_on = {8'd0, 8'd3}; tdd_channel_off = {8'd0, 8'd3};
         end
      endcase
   endtask

   task automatic chk(input string name, input logic [1:0] st, input logic [7:0] cnt,
                      input logic [1:0] ch, input logic eof, input logic eob);
      n_checks++;
      if ({tdd_cstate, tdd_counter, tdd_channel, tdd_endof_frame, tdd_endof_burst}
          !== {st, cnt, ch, eof, eob}) begin
         n_fail++;
         $display("FAIL %s: got st=%0d cnt=%0d ch=%b eof=%b eob=%b, expected st=%0d cnt=%0d ch=%b eof=%b eob=%b",
                  name, tdd_cstate, tdd_counter, tdd_channel, tdd_endof_frame, tdd_endof_burst,
                  st, cnt, ch, eof, eob);
      end
   endtask

   task automatic drv(input logic en, input logic sync, input logic srst, input logic upd);
      @(negedge clk);
      tdd_enable = en; tdd_sync = sync; tdd_sync_rst = srst; tdd_cfg_update = upd;
      #1;
   endtask

   initial begin
      // burst of two frames, delay 3, ch0 window 2..5
      add(0, 0,0,0,0, 2'd0, 0, 2'b00, 0, 0);
      add(0, 1,0,0,0, 2'd0, 0, 2'b00, 0, 0);
      add(0, 1,0,0,0, 2'd1, 0, 2'b00, 0, 0);
      add(0, 1,1,0,0, 2'd1, 0, 2'b00, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 1,0,0,0, 2'd2, i, 2'b00, 0, 0);
      for (int f = 0; f < 2; f++)
         for (int c = 0; c < 10; c++)
            add(0, 1,0,0,0, 2'd3, c, {1'b0, (c >= 3 && c <= 5)}, c == 9, f == 1 && c == 9);
      add(0, 1,0,0,0, 2'd1, 0, 2'b00, 0, 0);
      add(0, 1,0,0,0, 2'd1, 0, 2'b00, 0, 0);

      // endless run: ch0 2..7, ch1 active low 8..1 across the wrap
      add(1, 0,0,0,0, 2'd1, 0, 2'b00, 0, 0);
      add(1, 1,0,0,0, 2'd0, 0, 2'b00, 0, 0);
      add(1, 1,1,0,0, 2'd1, 0, 2'b10, 0, 0);
      add(1, 1,0,0,0, 2'd2, 0, 2'b10, 0, 0);
      add(1, 1,0,0,0, 2'd2, 1, 2'b10, 0, 0);
      for (int c = 0; c < 10; c++)
         add(1, 1,0,0,0, 2'd3, c, {c != 9, (c >= 3 && c <= 7)}, c == 9, 0);
      for (int c = 0; c < 10; c++)
         add(1, 1,0,0,0, 2'd3, c, {!(c == 9 || c <= 1), (c >= 3 && c <= 7)}, c == 9, 0);
      // resync at counter 6
      for (int c = 0; c < 7; c++)
         add(1, 1, c == 6, c == 6, 0, 2'd3, c, {!(c <= 1), (c >= 3 && c <= 7)}, 0, 0);
      // restarted frame: cfg update at 3, ignored sync at 6
      for (int c = 0; c < 10; c++)
         add(c >= 3 ? 2 : 1, 1, c == 6, 0, c == 3, 2'd3, c, {c != 9, (c >= 3 && c <= 7)}, c == 9, 0);
      // new frame length 4, ch0 off 4, ch1 on 8 out of range
      for (int c = 0; c < 5; c++)
         add(2, 1,0,0,0, 2'd3, c, {c > 1, c >= 3}, c == 4, 0);
      for (int c = 0; c < 5; c++)
         add(2, 1,0,0,0, 2'd3, c, {1'b1, c >= 3}, c == 4, 0);
      for (int c = 0; c < 5; c++)
         add(2, c != 4, 0,0,0, 2'd3, c, {1'b1, c >= 3}, c == 4, 0);
      add(2, 0,0,0,0, 2'd0, 0, 2'b10, 0, 0);
      add(2, 0,0,0,0, 2'd0, 0, 2'b10, 0, 0);

      rst = 1'b1;
      tdd_enable = 1'b0; tdd_sync = 1'b0; tdd_sync_rst = 1'b0; tdd_cfg_update = 1'b0;
      drive_cfg(0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset", 2'd0, 8'd0, 2'b00, 0, 0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive_cfg(tbl[i].cfg);
         tdd_enable = tbl[i].en; tdd_sync = tbl[i].sync;
         tdd_sync_rst = tbl[i].srst; tdd_cfg_update = tbl[i].upd;
         #1;
         chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].cnt, tbl[i].ch, tbl[i].eof, tbl[i].eob);
      end

      // reset while RUNNING
      drive_cfg(2);
      drv(1,0,0,0); chk("rst_seq_idle", 2'd0, 8'd0, 2'b10, 0, 0);
      drv(1,1,0,0); chk("rst_seq_armed", 2'd1, 8'd0, 2'b10, 0, 0);
      drv(1,0,0,0);
      drv(1,0,0,0); chk("rst_seq_wait", 2'd2, 8'd1, 2'b10, 0, 0);
      drv(1,0,0,0);
      drv(1,0,0,0);
      drv(1,0,0,0);
      drv(1,0,0,0); chk("rst_seq_run", 2'd3, 8'd3, 2'b11, 0, 0);
      rst = 1'b1;
      drv(0,0,0,0); chk("rst_seq_reset", 2'd0, 8'd0, 2'b00, 0, 0);
      rst = 1'b0;

      // zero delay, on == off: straight to RUNNING, channel stays off
      drive_cfg(3);
      drv(1,0,0,0); chk("d0_idle", 2'd0, 8'd0, 2'b00, 0, 0);
      drv(1,1,0,0); chk("d0_armed", 2'd1, 8'd0, 2'b00, 0, 0);
      for (int i = 0; i < 12; i++) begin
         drv(1,0,0,0);
         chk($sformatf("d0_run%0d", i), 2'd3, 8'(i % 5), 2'b00, (i % 5) == 4, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
